// File: rtl/rc4_prga_engine.sv
// rc4_prga_engine: RC4-n PRGA phase - swaps S[i]/S[j] and writes plaintext = keystream ^ ciphertext.
// Optional `RC4_VALID_CHECK_EN: stop on the first plaintext word outside {0x20, 0x61..0x7A}.
module rc4_prga_engine #(
    parameter int W      = 8,
    parameter int MSG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [MSG_AW:0]   msg_len,
    output logic              busy,
    output logic              done,
    output logic              invalid,
    output logic [W-1:0]      s_addr,
    output logic [W-1:0]      s_wdata,
    output logic              s_wren,
    input  logic [W-1:0]      s_rdata,
    output logic [MSG_AW-1:0] ct_addr,
    input  logic [W-1:0]      ct_rdata,
    output logic [MSG_AW-1:0] pt_addr,
    output logic [W-1:0]      pt_wdata,
    output logic              pt_wren
);
    typedef enum logic [3:0] {IDLE, RD_I, LAT_I, RD_J, LAT_J, WR_I, WR_J, RD_F, LAT_F, DONE} state_t;
    localparam logic [MSG_AW:0] MAX_LEN = {1'b1, {MSG_AW{1'b0}}};
    state_t state_q, state_d;
    logic [W-1:0] i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d;
    logic [MSG_AW-1:0] k_q, k_d;
    logic [MSG_AW:0] len_q, len_d;
    logic invalid_q, invalid_d;
    logic [W-1:0] pt_word;
    logic last, bad_word;
    assign pt_word = s_rdata ^ ct_rdata;
    // compare at MSG_AW+1 bits so a full-depth message ends at k = 2**MSG_AW-1
    assign last = {1'b0, k_q} == len_q - (MSG_AW+1)'(1);
`ifdef RC4_VALID_CHECK_EN
    if (W != 8) begin : g_bad_width
        $error("RC4_VALID_CHECK_EN requires W == 8");
    end
    assign bad_word = !(pt_word == W'(8'h20) || (pt_word >= W'(8'h61) && pt_word <= W'(8'h7A)));
`else
    assign bad_word = 1'b0;
`endif
    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        si_d      = si_q;
        sj_d      = sj_q;
        k_d       = k_q;
        len_d     = len_q;
        invalid_d = invalid_q;
        case (state_q)
            IDLE: if (start) begin
                len_d     = msg_len > MAX_LEN ? MAX_LEN : msg_len;
                i_d       = W'(1);
                j_d       = '0;
                k_d       = '0;
                invalid_d = 1'b0;
                state_d   = msg_len == '0 ? DONE : RD_I;
            end
            RD_I:  state_d = LAT_I;
            LAT_I: begin
                si_d    = s_rdata;
                j_d     = j_q + s_rdata;
                state_d = RD_J;
            end
            RD_J:  state_d = LAT_J;
            LAT_J: begin
                sj_d    = s_rdata;
                state_d = WR_I;
            end
            WR_I:  state_d = WR_J;
            WR_J:  state_d = RD_F;
            RD_F:  state_d = LAT_F;
            LAT_F: begin
                invalid_d = invalid_q | bad_word;
                if (last || bad_word) begin
                    state_d = DONE;
                end else begin
                    k_d     = k_q + MSG_AW'(1);
                    i_d     = i_q + W'(1);
                    state_d = RD_I;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            i_q       <= '0;
            j_q       <= '0;
            si_q      <= '0;
            sj_q      <= '0;
            k_q       <= '0;
            len_q     <= '0;
            invalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            j_q       <= j_d;
            si_q      <= si_d;
            sj_q      <= sj_d;
            k_q       <= k_d;
            len_q     <= len_d;
            invalid_q <= invalid_d;
        end
    end
    // when i == j the WR_J write (si) lands last, leaving S unchanged
    assign s_addr   = (state_q == RD_I || state_q == WR_I) ? i_q :
                      (state_q == RD_J || state_q == WR_J) ? j_q :
                      state_q == RD_F ? si_q + sj_q : '0;
    assign s_wdata  = state_q == WR_I ? sj_q : state_q == WR_J ? si_q : '0;
    assign s_wren   = state_q == WR_I || state_q == WR_J;
    assign ct_addr  = state_q == RD_F ? k_q : '0;
    assign pt_addr  = state_q == LAT_F ? k_q : '0;
    assign pt_wdata = state_q == LAT_F ? pt_word : '0;
    assign pt_wren  = state_q == LAT_F;
    assign busy     = state_q != IDLE;
    assign done     = state_q == DONE;
    assign invalid  = invalid_q;
endmodule

// File: tb/tb_rc4_prga_engine.sv
// tb_rc4_prga_engine: scoreboard bench comparing DUT plaintext writes, timing and S contents
// against a plain RC4 PRGA reference model.
module tb_rc4_prga_engine;
    localparam int W  = 8;
    localparam int AW = 5;
    localparam bit VCHK =
`ifdef RC4_VALID_CHECK_EN
        1'b1;
`else
        1'b0;
`endif
    typedef struct {
        logic [AW-1:0] a;
        logic [7:0]    d;
    } exp_t;

    logic clk = 0, rst = 1, start = 0, load = 0;
    logic [AW:0] msg_len = '0;
    logic busy, done, invalid, s_wren, pt_wren;
    logic [W-1:0] s_addr, s_wdata, s_rdata, ct_rdata, pt_wdata;
    logic [AW-1:0] ct_addr, pt_addr;
    logic [7:0] s_mem[256], s_init[256], s_exp[256], ct_mem[32], pt_mem[32];
    exp_t q[$];
    int checks = 0, fails = 0, swr_total = 0, busy_total = 0, last_pt = -1;

    rc4_prga_engine #(.W(W), .MSG_AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .msg_len(msg_len), .busy(busy), .done(done),
        .invalid(invalid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wren(s_wren), .s_rdata(s_rdata),
        .ct_addr(ct_addr), .ct_rdata(ct_rdata), .pt_addr(pt_addr), .pt_wdata(pt_wdata), .pt_wren(pt_wren)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (load) s_mem <= s_init;
        else if (s_wren) s_mem[s_addr] <= s_wdata;
        s_rdata  <= s_mem[s_addr];
        ct_rdata <= ct_mem[ct_addr];
        if (pt_wren) pt_mem[pt_addr] <= pt_wdata;
    end

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // monitor: pops the scoreboard whenever the DUT writes plaintext
    initial forever begin
        exp_t e;
        @(posedge clk);
        #1;
        if (pt_wren) begin
            if (q.size() == 0) chk("pt_unexpected_write", int'(pt_addr), -1);
            else begin
                e = q.pop_front();
                chk("pt_addr", int'(pt_addr), int'(e.a));
                chk("pt_data", int'(pt_wdata), int'(e.d));
            end
            last_pt = int'(pt_addr);
        end
        if (s_wren) swr_total++;
        if (busy) busy_total++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        fails++;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    function automatic bit ok_char(logic [7:0] p);
        return p == 8'h20 || (p >= 8'h61 && p <= 8'h7A);
    endfunction

    // reference RC4 PRGA over a snapshot of the current S memory
    task automatic model(int len, output int words, output bit inv);
        logic [7:0] sr[256];
        logic [7:0] t, p;
        int i = 0, j = 0;
        sr = s_mem;
        words = 0;
        inv = 0;
        for (int n = 0; n < len; n++) begin
            i = (i + 1) % 256;
            j = (j + sr[i]) % 256;
            t = sr[i]; sr[i] = sr[j]; sr[j] = t;
            p = ct_mem[n] ^ sr[(sr[i] + sr[j]) % 256];
            q.push_back('{a: AW'(n), d: p});
            words++;
            if (VCHK && !ok_char(p)) begin
                inv = 1;
                break;
            end
        end
        s_exp = sr;
    endtask

    task automatic load_s();
        @(negedge clk) load = 1;
        @(negedge clk) load = 0;
    endtask

    task automatic run(string tag, int mlen, bit poke);
        int words, cyc, nm, swr0, busy0;
        bit inv;
        model(mlen > 32 ? 32 : mlen, words, inv);
        @(negedge clk);
        msg_len = (AW+1)'(mlen);
        start = 1;
        swr0 = swr_total;
        busy0 = busy_total;
        @(posedge clk);
        #1 start = 0;
        cyc = 1;
        chk({tag, "_invalid_cleared"}, int'(invalid), 0);
        while (!done && cyc < 400) begin
            start = poke && cyc == 10;
            @(posedge clk);
            #1 cyc++;
        end
        start = 0;
        @(negedge clk);
        chk({tag, "_done_cycle"}, cyc, 1 + 8 * words);
        chk({tag, "_invalid"}, int'(invalid), int'(inv));
        chk({tag, "_busy_cycles"}, busy_total - busy0, 1 + 8 * words);
        chk({tag, "_s_writes"}, swr_total - swr0, 2 * words);
        chk({tag, "_scoreboard_left"}, q.size(), 0);
        if (words > 0) chk({tag, "_last_pt_addr"}, last_pt, words - 1);
        nm = 0;
        for (int x = 0; x < 256; x++) if (s_mem[x] !== s_exp[x]) nm++;
        chk({tag, "_s_final_mismatches"}, nm, 0);
        q.delete();
    endtask

    initial begin
        logic [7:0] key[3];
        logic [7:0] ctv[9];
        logic [7:0] t;
        int j, r, w;
        bit inv;
        int lens[4];
        key = '{8'h4B, 8'h65, 8'h79};
        ctv = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
        lens = '{5, 17, 40, 63};
        for (int x = 0; x < 32; x++) ct_mem[x] = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_invalid", int'(invalid), 0);
        chk("rst_s_wren", int'(s_wren), 0);
        chk("rst_pt_wren", int'(pt_wren), 0);
        chk("rst_s_addr", int'(s_addr), 0);
        chk("rst_s_wdata", int'(s_wdata), 0);
        chk("rst_ct_addr", int'(ct_addr), 0);
        chk("rst_pt_addr", int'(pt_addr), 0);
        chk("rst_pt_wdata", int'(pt_wdata), 0);
        rst = 0;
        // identity S, one word: i == j swap, keystream S[2] = 2
        for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
        load_s();
        ct_mem[0] = 8'h55;
        run("ident", 1, 0);
        chk("ident_pt0", int'(pt_mem[0]), 'h57);
        // KSA("Key") known-answer vector
        for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
        j = 0;
        for (int x = 0; x < 256; x++) begin
            j = (j + s_init[x] + key[x % 3]) % 256;
            t = s_init[x]; s_init[x] = s_init[j]; s_init[j] = t;
        end
        load_s();
        for (int x = 0; x < 9; x++) ct_mem[x] = ctv[x];
        run("key", 9, 1);
        chk("key_pt0", int'(pt_mem[0]), 'h50);
        run("len0", 0, 0);
        // random permutation, full-depth message
        for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
        for (int x = 255; x > 0; x--) begin
            r = $urandom_range(x, 0);
            t = s_init[x]; s_init[x] = s_init[r]; s_init[r] = t;
        end
        load_s();
        for (int x = 0; x < 32; x++) ct_mem[x] = 8'($urandom);
        run("rand32", 32, 1);
        for (int n = 0; n < 4; n++) begin
            for (int x = 0; x < 32; x++) ct_mem[x] = 8'($urandom);
            run($sformatf("rand_len%0d", lens[n]), lens[n], 1);
        end
        // reset mid-run at cycle 20, then a fresh run from the surviving S contents
        for (int x = 0; x < 32; x++) ct_mem[x] = 8'($urandom);
        model(9, w, inv);
        @(negedge clk);
        msg_len = 9;
        start = 1;
        @(posedge clk);
        #1 start = 0;
        repeat (19) @(posedge clk);
        #2 rst = 1;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_s_wren", int'(s_wren), 0);
        chk("midrst_pt_wren", int'(pt_wren), 0);
        @(negedge clk) rst = 0;
        q.delete();
        run("restart", 9, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
